// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between a UART and a combinational ALU: collects A, B and an
// opcode byte, launches the ALU result on the transmitter, and guards against stalls.
module uart_alu_ctrl #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done_tick,
    input  logic [DBIT-1:0]  rx_data,
    input  logic             tx_done_tick,
    input  logic [DBIT-1:0]  alu_result,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    output logic             tx_start,
    output logic [DBIT-1:0]  tx_data,
    output logic             busy,
    output logic             err_tout,
    output logic             err_ovr
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_WTX} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          expired;

    assign expired = (cnt == TMAX);
    assign busy    = (state != S_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_A;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            err_tout <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            err_tout <= 1'b0;
            err_ovr  <= 1'b0;
            case (state)
                S_A: begin
                    if (rx_done_tick) begin
                        alu_a <= rx_data;
                        cnt   <= '0;
                        state <= S_B;
                    end
                end
                // A byte arriving in the expiry cycle takes priority over the abort.
                S_B: begin
                    if (rx_done_tick) begin
                        alu_b <= rx_data;
                        cnt   <= '0;
                        state <= S_OP;
                    end else if (expired) begin
                        err_tout <= 1'b1;
                        cnt      <= '0;
                        state    <= S_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OP: begin
                    if (rx_done_tick) begin
                        alu_op <= rx_data[NB_OP-1:0];
                        cnt    <= '0;
                        state  <= S_EXEC;
                    end else if (expired) begin
                        err_tout <= 1'b1;
                        cnt      <= '0;
                        state    <= S_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    state    <= S_WTX;
                    if (rx_done_tick) err_ovr <= 1'b1;
                end
                S_WTX: begin
                    if (rx_done_tick) err_ovr <= 1'b1;
                    if (tx_done_tick) state <= S_A;
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl with a small behavioural ALU on alu_result.
module tb_uart_alu_ctrl;

    localparam int DBIT = 8;
    localparam int NB_OP = 6;
    localparam int TOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx_done_tick;
    logic [DBIT-1:0]  rx_data;
    logic             tx_done_tick;
    logic [DBIT-1:0]  alu_result;
    logic [DBIT-1:0]  alu_a, alu_b, tx_data;
    logic [NB_OP-1:0] alu_op;
    logic             tx_start, busy, err_tout, err_ovr;

    int n_chk = 0;
    int n_err = 0;
    int n_tx = 0;
    int n_tout = 0;
    int n_ovr = 0;
    logic [DBIT-1:0] sb_q[$];

    uart_alu_ctrl #(.DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_done_tick(tx_done_tick), .alu_result(alu_result), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .err_tout(err_tout), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [DBIT-1:0] alu_fn(input logic [NB_OP-1:0] op,
                                               input logic [DBIT-1:0] a, b);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output side of the scoreboard: every tx_start must match a queued result.
    always @(negedge clk) begin
        if (err_tout) n_tout++;
        if (err_ovr)  n_ovr++;
        if (tx_start) begin
            n_tx++;
            if (sb_q.size() == 0) chk("tx_unexpected", 1, 0);
            else chk("tx_data", {24'h0, tx_data}, {24'h0, sb_q.pop_front()});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [DBIT-1:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_done();
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
    endtask

    task automatic run_frame(input logic [DBIT-1:0] a, b, op);
        send_byte(a);
        send_byte(b);
        sb_q.push_back(alu_fn(op[NB_OP-1:0], a, b));
        send_byte(op);
        chk("lat_early", tx_start, 0);
        idle(1);
        chk("lat_start", tx_start, 1);
        idle(1);
        chk("start_once", tx_start, 0);
        chk("busy_wtx", busy, 1);
        idle(2);
        send_done();
        chk("busy_done", busy, 0);
    endtask

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b1;
        rx_data      = 8'h55;
        tx_done_tick = 1'b0;
        idle(2);
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_err", {err_tout, err_ovr, tx_start}, 0);

        // Stray tx_done in S_A and S_B, then a full ADD frame with an overrun byte.
        send_done();
        chk("txd_sa_busy", busy, 0);
        send_byte(8'h05);
        send_done();
        chk("txd_sb_busy", busy, 1);
        chk("txd_sb_start", tx_start, 0);
        send_byte(8'h03);
        chk("opnd_a", alu_a, 8'h05);
        chk("opnd_b", alu_b, 8'h03);
        sb_q.push_back(8'h08);
        send_byte(8'h20);
        chk("opnd_op", alu_op, 6'h20);
        chk("lat_early", tx_start, 0);
        idle(1);
        chk("lat_start", tx_start, 1);
        idle(1);
        chk("start_once", tx_start, 0);
        send_byte(8'h77);
        chk("ovr_pulse", err_ovr, 1);
        chk("ovr_txd", tx_data, 8'h08);
        chk("ovr_a", alu_a, 8'h05);
        chk("ovr_busy", busy, 1);
        idle(1);
        chk("ovr_clear", err_ovr, 0);
        send_done();
        chk("add_idle", busy, 0);

        // Timeout in S_B: pulse lands exactly TOUT cycles after the byte.
        send_byte(8'hAA);
        for (int i = 0; i < TOUT - 1; i++) begin
            chk("tout_early", err_tout, 0);
            idle(1);
        end
        chk("tout_early", err_tout, 0);
        idle(1);
        chk("tout_pulse", err_tout, 1);
        chk("tout_busy", busy, 0);
        chk("tout_b_hold", alu_b, 8'h03);
        chk("tout_op_hold", alu_op, 6'h20);
        idle(1);
        chk("tout_clear", err_tout, 0);
        run_frame(8'h01, 8'h02, 8'h20);

        // Byte arriving in the expiry cycle wins; then S_OP times out on its own.
        send_byte(8'h11);
        idle(TOUT - 1);
        send_byte(8'h22);
        chk("race_tout", err_tout, 0);
        chk("race_b", alu_b, 8'h22);
        chk("race_busy", busy, 1);
        for (int i = 0; i < TOUT - 1; i++) idle(1);
        chk("op_tout_early", err_tout, 0);
        idle(1);
        chk("op_tout_pulse", err_tout, 1);
        chk("op_tout_busy", busy, 0);
        chk("op_tout_hold", alu_op, 6'h20);
        run_frame(8'h11, 8'h22, 8'h25);

        // Reset while in S_EXEC cancels the pending transmit.
        send_byte(8'h40);
        send_byte(8'h01);
        send_byte(8'h20);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst_exec_start", tx_start, 0);
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_txd", tx_data, 0);
        idle(4);
        chk("rst_exec_ntx", n_tx, 3);
        run_frame(8'h10, 8'h01, 8'h22);
        chk("sub_txd", tx_data, 8'h0F);

        idle(2);
        chk("sb_empty", sb_q.size(), 0);
        chk("n_tx", n_tx, 4);
        chk("n_tout", n_tout, 2);
        chk("n_ovr", n_ovr, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
